// File: rtl/instr_fetch_resp.sv
// Return path of instruction fetch: pairs each issued address with the RAM word that
// comes back one cycle later, buffers {pc, instr} and hands them to decode.
module instr_fetch_resp #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fetch_enable_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  jump_flag_i,
    input  logic                  id_ready_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    output logic                  fetch_stall_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic                  pend_vld;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic                  pop;
    logic                  push;
    logic                  accept;
    logic [CW:0]           occupancy;

    // Handshake: an entry transfers on any cycle with instr_valid_o & id_ready_i; while
    // valid is high and ready low, the head {instr_pc_o, instr_o} is held unchanged.
    assign instr_valid_o = (count != '0);
    assign pop           = instr_valid_o & id_ready_i;

    // Entries already buffered plus the one in flight from the RAM, minus this cycle's pop.
    assign occupancy     = {1'b0, count} + (CW + 1)'(pend_vld) - (CW + 1)'(pop);
    assign fetch_stall_o = (occupancy >= (CW + 1)'(DEPTH));

    assign accept        = fetch_enable_i & ~fetch_stall_o & ~jump_flag_i;
    assign push          = pend_vld & ~jump_flag_i;

    assign instr_o       = instr_valid_o ? data_mem[rd_ptr] : NOP;
    assign instr_pc_o    = instr_valid_o ? pc_mem[rd_ptr]   : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_vld  <= 1'b0;
            pend_addr <= '0;
        end else begin
            pend_vld <= accept;
            if (accept) begin
                pend_addr <= instr_addr_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (jump_flag_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through a nonzero count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr]   <= pend_addr;
            data_mem[wr_ptr] <= mem_rdata_i;
        end
    end

endmodule
